// File: rtl/display_pkg.sv
// Shared types and constants for the out_display back-end: BCD digit type,
// converter state encoding, active-low 7-segment patterns and the
// combinational helpers used by the converter and the decoder.
package display_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_e;

  // The BCD register always holds ten nibbles, enough for any 32-bit value.
  localparam int BCD_NIBBLES = 10;
  localparam int BCD_W       = 4 * BCD_NIBBLES;
  localparam int BIN_W       = 32;
  localparam int CNT_W       = 5;
  localparam logic [CNT_W-1:0] SHIFT_LAST = 5'd31;

  // Digit index register is sized for the largest legal DIGITS (10).
  localparam int IDX_W = 4;

  // Active-low segment patterns, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Decimal digit to active-low segment pattern; non-decimal codes blank.
  function automatic logic [6:0] seg_decode(input bcd_digit_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction: add 3 to every nibble that is 5 or more so
  // the following left shift carries correctly into the next decade.
  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_NIBBLES; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to BCD converter (shift-add-3). Starts a new
// conversion whenever the input word differs from the last one converted,
// then publishes the displayed nibbles and an overflow flag in DONE.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      value_i,
  output logic                  busy_o,
  output logic                  ovf_o,
  output logic [4*DIGITS-1:0]   disp_bcd_o
);

  conv_state_e           state_q, state_d;
  logic [BIN_W-1:0]      sh_q, sh_d;
  logic [BIN_W-1:0]      last_q, last_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic                  ovf_q, ovf_d;
  logic                  done;
  logic [BCD_W-1:0]      adj;

  // Any non-zero nibble above the displayed range means the value does not fit.
  function automatic logic calc_ovf(input logic [BCD_W-1:0] b);
    logic o;
    o = 1'b0;
    for (int i = 0; i < BCD_NIBBLES; i++) begin
      if (i >= DIGITS && b[4*i +: 4] != 4'd0) o = 1'b1;
    end
    return o;
  endfunction

  // Strobe for the single cycle whose edge commits the finished result.
  assign done   = (state_q == DONE);
  assign busy_o = (state_q != IDLE);
  assign ovf_o  = ovf_q;
  assign disp_bcd_o = disp_q;

  // Next-state and datapath: load in IDLE, one correction+shift per SHIFT cycle.
  always_comb begin
    // NOTE: every variable gets its hold value first so no branch can leave it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    sh_d    = sh_q;
    last_d  = last_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    adj     = add3_all(bcd_q);

    case (state_q)
      IDLE: begin
        if (value_i != last_q) begin
          sh_d    = value_i;
          last_d  = value_i;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, sh_d} = {adj, sh_q} << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == SHIFT_LAST) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      disp_d = bcd_q[4*DIGITS-1:0];
      ovf_d  = calc_ovf(bcd_q);
    end
  end

  // State register; reset discards any partial conversion and the display.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      last_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      last_q  <= last_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: rtl/out_display.sv
// Time-multiplexed active-low 7-segment back-end for the CPU OUT word.
// Converts the word to decimal and scans DIGITS digits, one every
// 2^REFRESH_BITS cycles, with anode and cathode registered together.
// Build option: define OUT_DISPLAY_LZB_EN for leading-zero blanking.
module out_display
  import display_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int REFRESH_BITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       value,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              ovf
);

  localparam logic [DIGITS-1:0] AN_RST = ~DIGITS'(1);
`ifdef OUT_DISPLAY_LZB_EN
  localparam logic [6:0] SEG_RST = SEG_BLANK;
`else
  localparam logic [6:0] SEG_RST = SEG_0;
`endif

  logic [4*DIGITS-1:0]     disp_bcd;
  logic [REFRESH_BITS-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  bcd_digit_t              nib;
  logic                    blank;
`ifdef OUT_DISPLAY_LZB_EN
  logic                    zero_run;
`endif

  bin2bcd_seq #(
    .DIGITS (DIGITS)
  ) u_conv (
    .clk        (clk),
    .rst        (rst),
    .value_i    (value),
    .busy_o     (busy),
    .ovf_o      (ovf),
    .disp_bcd_o (disp_bcd)
  );

  assign seg = seg_q;
  assign an  = an_q;

  // Prescaler, digit index and the anode/segment pattern for the next index.
  always_comb begin
    presc_d = presc_q + REFRESH_BITS'(1);
    idx_d   = idx_q;
    if (&presc_q) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    nib  = '0;
    an_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx_d) begin
        nib     = disp_bcd[4*i +: 4];
        an_d[i] = 1'b0;
      end
    end

    blank = 1'b0;
`ifdef OUT_DISPLAY_LZB_EN
    // Walk from the top digit down; a digit is blank while everything at and
    // above it is zero. Digit 0 always shows so a zero value reads "0".
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (disp_bcd[4*i +: 4] == 4'd0);
      if (IDX_W'(i) == idx_d && i != 0) blank = zero_run;
    end
`endif

    seg_d = ovf ? SEG_DASH : (blank ? SEG_BLANK : seg_decode(nib));
  end

  // Scan registers; anode and cathode load on the same edge to avoid ghosting.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= AN_RST;
      seg_q   <= SEG_RST;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

endmodule

// File: tb/tb_out_display.sv
// Directed bench for out_display: an 8-digit and a 10-digit instance share
// clock, reset and value; displayed digits are collected from the scan and
// compared against a decimal model of the value.
module tb_out_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic [6:0]  seg8, seg10;
  logic [7:0]  an8;
  logic [9:0]  an10;
  logic        busy8, busy10, ovf8, ovf10;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
`ifdef OUT_DISPLAY_LZB_EN
  localparam logic [6:0] SEG_AT_RESET = BLANK;
`else
  localparam logic [6:0] SEG_AT_RESET = 7'b1000000;
`endif

  out_display #(.DIGITS(8), .REFRESH_BITS(2)) u_dut (
    .clk(clk), .rst(rst), .value(value),
    .seg(seg8), .an(an8), .busy(busy8), .ovf(ovf8)
  );

  out_display #(.DIGITS(10), .REFRESH_BITS(2)) u_dut10 (
    .clk(clk), .rst(rst), .value(value),
    .seg(seg10), .an(an10), .busy(busy10), .ovf(ovf10)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scan capture: last pattern seen for each anode position.
  logic [6:0] cap8  [8];
  logic [6:0] cap10 [10];
  logic [7:0] seen8;
  logic [9:0] seen10;
  logic       onehot_ok;
  logic       busy_seen;

  task automatic capture(input int ncyc);
    seen8 = '0; seen10 = '0; onehot_ok = 1'b1; busy_seen = 1'b0;
    repeat (ncyc) begin
      @(negedge clk);
      if ($countones(~an8) != 1 || $countones(~an10) != 1) onehot_ok = 1'b0;
      if (busy8) busy_seen = 1'b1;
      for (int i = 0; i < 8; i++)
        if (!an8[i]) begin cap8[i] = seg8; seen8[i] = 1'b1; end
      for (int i = 0; i < 10; i++)
        if (!an10[i]) begin cap10[i] = seg10; seen10[i] = 1'b1; end
    end
  endtask

  // Decimal model of what digit i of an ndig-digit display must show.
  function automatic logic [6:0] exp_seg(input longint unsigned v, input int i, input int ndig);
    longint unsigned p, lim;
    p = 1; lim = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    for (int k = 0; k < ndig; k++) lim = lim * 10;
    if (v >= lim) return DASH;
`ifdef OUT_DISPLAY_LZB_EN
    if (i > 0 && v < p) return BLANK;
`endif
    return seg_tbl[int'((v / p) % 10)];
  endfunction

  task automatic check_display8(input string tag, input longint unsigned v);
    check({tag, "_seen8"}, seen8, 8'hFF);
    check({tag, "_onehot"}, onehot_ok, 1'b1);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_d%0d", tag, i), cap8[i], exp_seg(v, i, 8));
  endtask

  task automatic check_display10(input string tag, input longint unsigned v);
    check({tag, "_seen10"}, seen10, 10'h3FF);
    for (int i = 0; i < 10; i++)
      check($sformatf("%s_d10_%0d", tag, i), cap10[i], exp_seg(v, i, 10));
  endtask

  // Bounded wait for busy to reach a level; n returns cycles waited.
  task automatic wait_busy(input string tag, input logic level, input int maxc, output int n);
    n = 0;
    while (busy8 !== level && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy8, level);
  endtask

  task automatic convert(input string tag, input logic [31:0] v);
    int n;
    value = v;
    wait_busy({tag, "_start"}, 1'b1, 4, n);
    wait_busy({tag, "_end"}, 1'b0, 40, n);
    @(negedge clk);
    capture(44);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, n_busy, gap;

    // Reset state with value 0.
    rst = 1'b1; value = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_ovf", ovf8, 1'b0);
    check("rst_an", an8, 8'b11111110);
    check("rst_an10", an10, 10'h3FE);
    check("rst_seg", seg8, SEG_AT_RESET);
    rst = 1'b0;
    capture(44);
    check("rst_no_conv", busy_seen, 1'b0);
    check_display8("zero", 0);

    // value 4: busy width and a single non-zero digit.
    value = 32'd4;
    wait_busy("v4_start", 1'b1, 4, n);
    n_busy = 0;
    while (busy8 === 1'b1 && n_busy < 100) begin
      n_busy++;
      @(negedge clk);
    end
    check("v4_busy_cycles", n_busy, 33);
    @(negedge clk);
    capture(44);
    check_display8("v4", 4);

    // Eight full digits, no overflow.
    convert("v12345678", 32'd12345678);
    check("v12345678_ovf", ovf8, 1'b0);
    check_display8("v12345678", 12345678);

    // All ones: overflows eight digits, fits ten.
    convert("vmax", 32'hFFFF_FFFF);
    check("vmax_ovf8", ovf8, 1'b1);
    check("vmax_ovf10", ovf10, 1'b0);
    check_display8("vmax", 64'd4294967295);
    check_display10("vmax", 64'd4294967295);

    // Change 5 -> 9 mid-conversion: 5 completes first, then 9 one IDLE later.
    value = 32'd5;
    wait_busy("chg_start", 1'b1, 4, n);
    repeat (10) @(negedge clk);
    value = 32'd9;
    wait_busy("chg_first_end", 1'b0, 40, n);
    @(negedge clk);
    check("chg_restart", busy8, 1'b1);
    capture(32);
    check_display8("chg_first", 5);
    wait_busy("chg_second_end", 1'b0, 10, n);
    gap = 33 + n;
    check("chg_second_latency", gap, 34);
    @(negedge clk);
    capture(44);
    check_display8("chg_second", 9);

    // Reset in the middle of converting 999.
    value = 32'd999;
    wait_busy("abort_start", 1'b1, 4, n);
    repeat (15) @(negedge clk);
    rst = 1'b1; value = 32'd0;
    @(negedge clk);
    check("abort_busy", busy8, 1'b0);
    check("abort_ovf", ovf8, 1'b0);
    check("abort_an", an8, 8'b11111110);
    check("abort_seg", seg8, SEG_AT_RESET);
    rst = 1'b0;
    capture(44);
    check("abort_no_conv", busy_seen, 1'b0);
    check_display8("abort", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
